// File: rtl/sram_responder_pkg.sv
// Shared types, MMIO register offsets and the byte-lane merge helper used by
// both the RAM write path and the MMIO registers of the sram responder.
package sram_responder_params;

   typedef logic [31:0] SramAddress;
   typedef logic [31:0] SramData;
   typedef logic [3:0]  SramStrobe;

   localparam logic [15:0] LED_OFFSET         = 16'h0000;
   localparam logic [15:0] SCRATCH0_OFFSET    = 16'h0004;
   localparam logic [15:0] SCRATCH1_OFFSET    = 16'h0008;
   localparam logic [15:0] TIMER_OFFSET       = 16'h000C;
   localparam logic [15:0] FAULT_COUNT_OFFSET = 16'h0010;

   // Lane i of the result comes from newWord when strobe[i] is set, else oldWord.
   function automatic SramData mergeBytes(input SramData oldWord,
                                          input SramData newWord,
                                          input SramStrobe strobe);
      SramData merged;
      merged = oldWord;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) begin
            merged[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/sram_responder_mmio.sv
// MMIO window of the sram responder: LED, two scratch words, a free-running
// timer and a saturating count of accesses to undefined offsets.
module sram_responder_mmio
   import sram_responder_params::*;
(
   input  logic        clock,
   input  logic        reset_,
   input  logic        i_select,
   input  SramStrobe   i_strobe,
   input  logic [13:0] i_wordOffset,
   input  SramData     i_writeData,
   output SramData     o_readData,
   output logic [15:0] o_led,
   output SramData     o_timer,
   output logic        o_fault
);

   logic [15:0] r_led;
   SramData     r_scratch0;
   SramData     r_scratch1;
   SramData     r_timer;
   SramData     r_faultCount;
   logic        r_fault;

   logic w_hitLed;
   logic w_hitScratch0;
   logic w_hitScratch1;
   logic w_hitTimer;
   logic w_hitFaultCount;
   logic w_write;
   logic w_undefined;

   // Offsets are compared on word granularity so misaligned accesses alias to the word.
   assign w_hitLed        = (i_wordOffset == LED_OFFSET[15:2]);
   assign w_hitScratch0   = (i_wordOffset == SCRATCH0_OFFSET[15:2]);
   assign w_hitScratch1   = (i_wordOffset == SCRATCH1_OFFSET[15:2]);
   assign w_hitTimer      = (i_wordOffset == TIMER_OFFSET[15:2]);
   assign w_hitFaultCount = (i_wordOffset == FAULT_COUNT_OFFSET[15:2]);

   assign w_write     = i_select && (i_strobe != 4'b0000);
   assign w_undefined = i_select && !(w_hitLed || w_hitScratch0 || w_hitScratch1 ||
                                      w_hitTimer || w_hitFaultCount);

   always_comb begin
      o_readData = '0;
      if (w_hitLed) begin
         o_readData = {16'h0000, r_led};
      end else if (w_hitScratch0) begin
         o_readData = r_scratch0;
      end else if (w_hitScratch1) begin
         o_readData = r_scratch1;
      end else if (w_hitTimer) begin
         o_readData = r_timer;
      end else if (w_hitFaultCount) begin
         o_readData = r_faultCount;
      end
   end

   // A timer write replaces that cycle's increment rather than adding to it.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_led        <= '0;
         r_scratch0   <= '0;
         r_scratch1   <= '0;
         r_timer      <= '0;
         r_faultCount <= '0;
         r_fault      <= 1'b0;
      end else begin
         r_fault <= w_undefined;
         if (w_undefined && (r_faultCount != 32'hFFFF_FFFF)) begin
            r_faultCount <= r_faultCount + 32'd1;
         end
         if (w_write && w_hitTimer) begin
            r_timer <= mergeBytes(r_timer, i_writeData, i_strobe);
         end else begin
            r_timer <= r_timer + 32'd1;
         end
         if (w_write && w_hitLed) begin
            if (i_strobe[0]) begin
               r_led[7:0] <= i_writeData[7:0];
            end
            if (i_strobe[1]) begin
               r_led[15:8] <= i_writeData[15:8];
            end
         end
         if (w_write && w_hitScratch0) begin
            r_scratch0 <= mergeBytes(r_scratch0, i_writeData, i_strobe);
         end
         if (w_write && w_hitScratch1) begin
            r_scratch1 <= mergeBytes(r_scratch1, i_writeData, i_strobe);
         end
      end
   end

   assign o_led   = r_led;
   assign o_timer = r_timer;
   assign o_fault = r_fault;

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for one sram-like core interface: word-addressed RAM
// plus an MMIO window, with read-first, single-cycle registered read data.
module sram_responder
   import sram_responder_params::*;
#(
   parameter int          DEPTH_LOG2   = 16,
   parameter logic [15:0] MMIO_BASE_HI = 16'hbfaf,
   parameter string       INIT_FILE    = ""
)
(
   input  logic        clock,
   input  logic        reset_,
   input  logic        ram_enabled,
   input  SramStrobe   ram_write_strobe,
   input  SramAddress  ram_address,
   input  SramData     ram_write_data,
   output SramData     ram_read_data,
   output logic [15:0] led,
   output SramData     timer_count,
   output logic        access_fault
);

   localparam bit UnusedPreloadRequested = (INIT_FILE != "");

   SramData r_mem [2**DEPTH_LOG2];
   SramData r_readData;

   logic                  w_isMmio;
   logic                  w_mmioSelect;
   logic                  w_ramWrite;
   logic [DEPTH_LOG2-1:0] w_ramIndex;
   SramData               w_ramWord;
   SramData               w_mmioReadData;
   logic                  w_unusedByteOffset;

   assign w_isMmio           = (ram_address[31:16] == MMIO_BASE_HI);
   assign w_mmioSelect       = ram_enabled && w_isMmio;
   assign w_ramWrite         = ram_enabled && !w_isMmio && (ram_write_strobe != 4'b0000);
   assign w_ramIndex         = ram_address[DEPTH_LOG2+1:2];
   assign w_ramWord          = r_mem[w_ramIndex];
   assign w_unusedByteOffset = ^ram_address[1:0];

   sram_responder_mmio u_mmio (
      .clock        (clock),
      .reset_       (reset_),
      .i_select     (w_mmioSelect),
      .i_strobe     (ram_write_strobe),
      .i_wordOffset (ram_address[15:2]),
      .i_writeData  (ram_write_data),
      .o_readData   (w_mmioReadData),
      .o_led        (led),
      .o_timer      (timer_count),
      .o_fault      (access_fault)
   );

   // RAM contents survive reset, so the array has no reset branch.
   always_ff @(posedge clock) begin
      if (w_ramWrite) begin
         r_mem[w_ramIndex] <= mergeBytes(w_ramWord, ram_write_data, ram_write_strobe);
      end
   end

   // Captures the pre-write word on any enabled access; holds while idle.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         r_readData <= '0;
      end else if (ram_enabled) begin
         r_readData <= w_isMmio ? w_mmioReadData : w_ramWord;
      end
   end

   assign ram_read_data = r_readData;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed scenarios followed by random
// traffic, all compared against a behavioural model of the memory map.
module tb_sram_responder;

   logic        clock = 1'b0;
   logic        reset_;
   logic        ram_enabled;
   logic [3:0]  ram_write_strobe;
   logic [31:0] ram_address;
   logic [31:0] ram_write_data;
   logic [31:0] ram_read_data;
   logic [15:0] led;
   logic [31:0] timer_count;
   logic        access_fault;

   int total = 0;
   int bad   = 0;

   logic [31:0] mMem [int];
   logic [15:0] mLed;
   logic [31:0] mScratch0;
   logic [31:0] mScratch1;
   logic [31:0] mTimer;
   logic [31:0] mFaultCount;
   logic [31:0] mRead;
   bit          mReadKnown;
   bit          mFault;

   always #5 clock = ~clock;

   sram_responder #(
      .DEPTH_LOG2   (16),
      .MMIO_BASE_HI (16'hbfaf),
      .INIT_FILE    ("")
   ) dut (
      .clock            (clock),
      .reset_           (reset_),
      .ram_enabled      (ram_enabled),
      .ram_write_strobe (ram_write_strobe),
      .ram_address      (ram_address),
      .ram_write_data   (ram_write_data),
      .ram_read_data    (ram_read_data),
      .led              (led),
      .timer_count      (timer_count),
      .access_fault     (access_fault)
   );

   function automatic logic [31:0] mergeRef(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0] strobe);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (strobe[i]) mask = mask | (32'hFF << (8 * i));
      end
      return (oldWord & ~mask) | (newWord & mask);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mLed        = 16'h0;
      mScratch0   = 32'h0;
      mScratch1   = 32'h0;
      mTimer      = 32'h0;
      mFaultCount = 32'h0;
      mRead       = 32'h0;
      mReadKnown  = 1'b1;
      mFault      = 1'b0;
   endtask

   // Drives one cycle from a falling edge, advances the model, checks after the rising edge.
   task automatic applyStimulus(input logic en, input logic [3:0] strb,
                                input logic [31:0] addr, input logic [31:0] data);
      bit          isMmio;
      logic [15:0] off;
      int          idx;
      logic [31:0] nextTimer;
      logic [31:0] tmp;
      bit          fault;
      ram_enabled      = en;
      ram_write_strobe = strb;
      ram_address      = addr;
      ram_write_data   = data;
      isMmio    = (addr[31:16] == 16'hbfaf);
      off       = {addr[15:2], 2'b00};
      idx       = int'((addr >> 2) & 32'h0000_FFFF);
      nextTimer = mTimer + 32'd1;
      fault     = 1'b0;
      if (en) begin
         if (isMmio) begin
            mReadKnown = 1'b1;
            case (off)
               16'h0000: begin
                  mRead = {16'h0, mLed};
                  tmp   = mergeRef({16'h0, mLed}, data, strb);
                  mLed  = tmp[15:0];
               end
               16'h0004: begin mRead = mScratch0; mScratch0 = mergeRef(mScratch0, data, strb); end
               16'h0008: begin mRead = mScratch1; mScratch1 = mergeRef(mScratch1, data, strb); end
               16'h000C: begin
                  mRead = mTimer;
                  if (strb != 4'h0) nextTimer = mergeRef(mTimer, data, strb);
               end
               16'h0010: mRead = mFaultCount;
               default: begin mRead = 32'h0; fault = 1'b1; end
            endcase
         end else begin
            if (mMem.exists(idx)) begin
               mRead      = mMem[idx];
               mReadKnown = 1'b1;
               if (strb != 4'h0) mMem[idx] = mergeRef(mMem[idx], data, strb);
            end else begin
               mReadKnown = 1'b0;
               if (strb == 4'hF) mMem[idx] = data;
            end
         end
      end
      if (fault && (mFaultCount != 32'hFFFF_FFFF)) mFaultCount = mFaultCount + 32'd1;
      mFault = fault;
      mTimer = nextTimer;
      @(posedge clock);
      #1;
      if (mReadKnown) checkOutput("readData", ram_read_data, mRead);
      checkOutput("timer", timer_count, mTimer);
      checkOutput("led", {16'h0, led}, {16'h0, mLed});
      checkOutput("fault", {31'h0, access_fault}, {31'h0, mFault});
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic pulseReset(input logic en, input logic [31:0] addr);
      reset_           = 1'b0;
      ram_enabled      = en;
      ram_write_strobe = 4'h0;
      ram_address      = addr;
      #1;
      checkOutput("resetAsyncRead", ram_read_data, 32'h0);
      repeat (3) @(negedge clock);
      reset_      = 1'b1;
      ram_enabled = 1'b0;
      modelReset();
      #1;
      checkOutput("releaseRead", ram_read_data, 32'h0);
      checkOutput("releaseLed", {16'h0, led}, 32'h0);
      checkOutput("releaseTimer", timer_count, 32'h0);
      checkOutput("releaseFault", {31'h0, access_fault}, 32'h0);
   endtask

   initial begin
      logic [31:0] ramPool [6];
      logic [15:0] mmioPool [8];
      logic [31:0] a;
      logic [3:0]  s;
      ramPool  = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_0010,
                   32'h0000_FFFC, 32'h0003_FFFC};
      mmioPool = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014,
                   16'h0020, 16'h0100};
      reset_           = 1'b0;
      ram_enabled      = 1'b0;
      ram_write_strobe = 4'h0;
      ram_address      = 32'h0;
      ram_write_data   = 32'h0;
      @(negedge clock);
      pulseReset(1'b0, 32'h0);
      idle(2);

      $display("[TB] full write / aliased read");
      applyStimulus(1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 4'h0, 32'h0000_1000, 32'h0);
      checkOutput("fullRead", ram_read_data, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 4'h0, 32'h0004_1000, 32'h0);
      checkOutput("aliasRead", ram_read_data, 32'hDEAD_BEEF);

      $display("[TB] byte strobes and read-first");
      applyStimulus(1'b1, 4'hF, 32'h0000_2000, 32'h1122_3344);
      applyStimulus(1'b1, 4'h5, 32'h0000_2000, 32'hAABB_CCDD);
      checkOutput("readFirst", ram_read_data, 32'h1122_3344);
      applyStimulus(1'b1, 4'h0, 32'h0000_2000, 32'h0);
      checkOutput("mergedRead", ram_read_data, 32'h11BB_33DD);
      idle(1);
      checkOutput("idleHold", ram_read_data, 32'h11BB_33DD);

      $display("[TB] timer wrap and read");
      applyStimulus(1'b1, 4'hF, 32'hbfaf_000C, 32'hFFFF_FFFE);
      checkOutput("timerLoad", timer_count, 32'hFFFF_FFFE);
      idle(2);
      checkOutput("timerWrap", timer_count, 32'h0);
      idle(5);
      applyStimulus(1'b1, 4'h0, 32'hbfaf_000C, 32'h0);
      checkOutput("timerRead", ram_read_data, 32'h5);

      $display("[TB] fault path");
      applyStimulus(1'b1, 4'h0, 32'hbfaf_0020, 32'h0);
      checkOutput("faultRead", ram_read_data, 32'h0);
      checkOutput("faultPulse", {31'h0, access_fault}, 32'h1);
      idle(1);
      checkOutput("faultDrop", {31'h0, access_fault}, 32'h0);
      applyStimulus(1'b1, 4'h0, 32'hbfaf_0010, 32'h0);
      checkOutput("faultCount", ram_read_data, 32'h1);
      applyStimulus(1'b1, 4'hF, 32'hbfaf_0010, 32'h1234_5678);
      applyStimulus(1'b1, 4'h0, 32'hbfaf_0010, 32'h0);
      checkOutput("faultCountRo", ram_read_data, 32'h1);

      $display("[TB] LED and scratch");
      applyStimulus(1'b1, 4'hF, 32'hbfaf_0000, 32'h0001_FFFF);
      checkOutput("ledValue", {16'h0, led}, 32'h0000_FFFF);
      applyStimulus(1'b1, 4'h0, 32'hbfaf_0000, 32'h0);
      checkOutput("ledRead", ram_read_data, 32'h0000_FFFF);
      applyStimulus(1'b1, 4'h8, 32'hbfaf_0004, 32'h7F00_0000);
      applyStimulus(1'b1, 4'h0, 32'hbfaf_0004, 32'h0);
      checkOutput("scratch0", ram_read_data, 32'h7F00_0000);

      $display("[TB] mid-stream reset");
      applyStimulus(1'b1, 4'h0, 32'h0000_1000, 32'h0);
      pulseReset(1'b1, 32'h0000_1000);
      idle(2);
      applyStimulus(1'b1, 4'h0, 32'h0000_1000, 32'h0);
      checkOutput("ramSurvives", ram_read_data, 32'hDEAD_BEEF);

      $display("[TB] random traffic");
      foreach (ramPool[i]) applyStimulus(1'b1, 4'hF, ramPool[i], $urandom);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = ramPool[$urandom_range(0, 5)] + ($urandom_range(0, 15) << 18) + $urandom_range(0, 3);
         end else begin
            a = {16'hbfaf, mmioPool[$urandom_range(0, 7)]} + $urandom_range(0, 3);
         end
         s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         applyStimulus(($urandom_range(0, 4) != 0), s, a, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the core's sram-like instruction/data interfaces. Accepts enable, byte-strobe, address and write data from the initiator, and returns registered read data one cycle later.
- Backs a word-addressed on-chip RAM array plus a small MMIO register window: LED, two scratch registers, a free-running timer and a fault counter.
- Used by the SoC top and the testbench, once per core interface (instruction and data).

Parameters:
- DEPTH_LOG2, 16, log2 of RAM depth in 32-bit words.
- MMIO_BASE_HI, 16'hbfaf, address[31:16] value selecting the MMIO window.
- INIT_FILE, "", hex file loaded into RAM at elaboration; empty = no preload.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- ram_enabled  in  1  access request this cycle
- ram_write_strobe  in  4  byte write enables; 0 = read
- ram_address  in  32  byte address; bits [1:0] ignored
- ram_write_data  in  32  write data, byte lane i = bits [8i+7:8i]
- ram_read_data  out  32  read data, valid the cycle after a read request
- led  out  16  LED register
- timer_count  out  32  current timer value
- access_fault  out  1  one-cycle pulse on an undefined MMIO access

Behaviour:
- Reset (reset_ low, asynchronous):
  - ram_read_data=0, led=0, scratch0/1=0, timer_count=0, fault_count=0, access_fault=0.
  - RAM contents are not cleared. Reset release is used synchronously; mid-operation reset discards any in-flight read, and the first cycle after release returns 0.
- Decode:
  - MMIO if ram_address[31:16]==MMIO_BASE_HI, else RAM.
  - RAM index = ram_address[DEPTH_LOG2+1:2]; higher address bits alias.
- Read (enabled, strobe==0):
  - ram_read_data updates at the next rising edge and holds until the next enabled access. Latency is exactly 1 cycle; there is no stall or handshake.
  - Back-to-back reads every cycle return in order, one per cycle.
- Write (enabled, strobe!=0):
  - Only bytes with strobe bit set change.
  - ram_read_data after a write cycle = pre-write word of the addressed location (read-first).
  - A read of the same address in the following cycle returns the merged new word.
- Idle (enabled=0): no state change except timer and access_fault; ram_read_data holds its value.
- MMIO offsets (ram_address[15:0]):
  - 0x0000 LED: bits [15:0] writable, read-zero-extended.
  - 0x0004 SCRATCH0: full 32-bit read/write.
  - 0x0008 SCRATCH1: full 32-bit read/write.
  - 0x000C TIMER: increments by 1 every cycle, wraps 0xFFFFFFFF->0.
    - A write merges strobed bytes into the current (pre-increment) value; no increment that cycle.
    - A read returns the value in the request cycle.
  - 0x0010 FAULT_COUNT: read-only, 32-bit, saturating at 0xFFFFFFFF; writes ignored.
  - Any other offset: read returns 0, write ignored, access_fault pulses high the next cycle, fault_count increments.
  - Simultaneous events on the same edge (a fault while FAULT_COUNT is read) return the pre-increment count.
- Strobe semantics are identical for RAM and MMIO; misaligned addresses are treated as aligned.

Decomposition:
- Package sram_responder_params:
  - MMIO offset constants (LED_OFFSET, SCRATCH0_OFFSET, SCRATCH1_OFFSET, TIMER_OFFSET, FAULT_COUNT_OFFSET).
  - Typedefs SramAddress, SramData, SramStrobe.
  - A byte-merge function (old, new, strobe) -> merged word.
- Sub-module sram_responder_mmio: MMIO registers, timer, fault counter and access_fault pulse. The parent holds the RAM array and the output read-data mux/register.

Test Plan:
- Reset: hold reset_ low 3 cycles mid-stream, release -> ram_read_data=0, led=0, timer_count=0 the first cycle after release, then timer_count=1, 2, ...
- Full write/read: write 0xDEADBEEF strobe 4'b1111 to 0x00001000, then read 0x00001000 -> ram_read_data=0xDEADBEEF exactly 1 cycle after the read request; aliased read at 0x00041000 (DEPTH_LOG2=16) returns the same word.
- Byte strobes / read-first: word holds 0x11223344, write 0xAABBCCDD strobe 4'b0101 -> read data after the write cycle = 0x11223344; an immediate re-read returns 0x11BB33DD.
- Timer: write 0xFFFFFFFE strobe 4'b1111 to 0xbfaf000C -> timer_count=0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000; a read issued when the count is 0x5 returns 0x5.
- Fault path: read 0xbfaf0020 -> ram_read_data=0, access_fault high for exactly one cycle; a subsequent FAULT_COUNT read returns 1; a write to FAULT_COUNT leaves it 1.
- MMIO registers: write 0x0001FFFF strobe 4'b1111 to LED -> led=0xFFFF and readback 0x0000FFFF; SCRATCH0 partial write strobe 4'b1000 of 0x7F000000 over 0 reads back 0x7F000000.
